// File: rtl/modulo_controle_jogo_pkg.sv
// Shared encodings and small helpers for the naval-battle game-flow controller.
package modulo_controle_jogo_pkg;

  typedef enum logic [2:0] {
    POSICIONA,
    ATAQUE,
    AVALIA,
    VITORIA,
    DERROTA
  } estado_t;

  localparam logic [1:0] ST_POSICIONANDO = 2'b00;
  localparam logic [1:0] ST_ATACANDO     = 2'b01;
  localparam logic [1:0] ST_VITORIA      = 2'b10;
  localparam logic [1:0] ST_DERROTA      = 2'b11;

  localparam logic [1:0] RES_NENHUM    = 2'b00;
  localparam logic [1:0] RES_AGUA      = 2'b01;
  localparam logic [1:0] RES_ACERTO    = 2'b10;
  localparam logic [1:0] RES_REJEITADO = 2'b11;

  // Board is 7 lines x 5 columns; highest legal index of each.
  localparam logic [2:0] LINHA_MAX  = 3'd6;
  localparam logic [2:0] COLUNA_MAX = 3'd4;

  localparam logic [3:0] CONT_SAT = 4'd15;

  function automatic logic alvo_valido(input logic [5:0] alvo);
    return (alvo[5:3] <= LINHA_MAX) && (alvo[2:0] <= COLUNA_MAX);
  endfunction

  function automatic logic [3:0] inc_sat(input logic [3:0] v);
    return (v == CONT_SAT) ? v : v + 4'd1;
  endfunction

  function automatic logic [3:0] dec_sat(input logic [3:0] v);
    return (v == 4'd0) ? v : v - 4'd1;
  endfunction

  function automatic logic [1:0] status_de(input estado_t e);
    case (e)
      POSICIONA: return ST_POSICIONANDO;
      VITORIA:   return ST_VITORIA;
      DERROTA:   return ST_DERROTA;
      default:   return ST_ATACANDO;
    endcase
  endfunction

endpackage

// File: rtl/modulo_controle_jogo_if.sv
// Board-side bundle: raw button, target selection, matrix cell bits, strobes and status.
interface modulo_controle_jogo_if;
  logic       button_clk;
  logic [5:0] hh2;
  logic       cell_navio;
  logic       cell_atacada;
  logic       po_load;
  logic       at_write;
  logic       mat_clr;
  logic [1:0] status;
  logic [1:0] resultado;
  logic [3:0] ataques_rest;
  logic [3:0] acertos;

  modport master (
    input  button_clk, hh2, cell_navio, cell_atacada,
    output po_load, at_write, mat_clr, status, resultado, ataques_rest, acertos
  );

  modport slave (
    output button_clk, hh2, cell_navio, cell_atacada,
    input  po_load, at_write, mat_clr, status, resultado, ataques_rest, acertos
  );
endinterface

// File: rtl/modulo_debounce_pulso.sv
// Button conditioning: 2-FF synchronizer, debounce counter, one-cycle pulse on press (high->low).
module modulo_debounce_pulso #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic conf_o
);

  localparam int             CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             nivel_q, nivel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             conf_q, conf_d;

  // cnt_q counts consecutive samples that disagree with the accepted level.
  always_comb begin
    nivel_d = nivel_q;
    cnt_d   = cnt_q;
    if (sync_q[1] == nivel_q) begin
      cnt_d = '0;
    end else if (cnt_q == LIM) begin
      nivel_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    conf_d = nivel_q & ~nivel_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      nivel_q <= 1'b1;
      cnt_q   <= '0;
      conf_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_n_i};
      nivel_q <= nivel_d;
      cnt_q   <= cnt_d;
      conf_q  <= conf_d;
    end
  end

  assign conf_o = conf_q;

endmodule

// File: rtl/modulo_controle_jogo.sv
// Game-flow FSM: placement, attacks, evaluation and end-of-game, with registered strobes and counters.
module modulo_controle_jogo
  import modulo_controle_jogo_pkg::*;
#(
  parameter int DEB_CYCLES   = 500000,
  parameter int MAX_ATAQUES  = 12,
  parameter int HITS_VITORIA = 6
) (
  input  logic                          clk,
  input  logic                          clr,
  modulo_controle_jogo_if.master        bus
);

  localparam logic [3:0] ATAQUES_INI = 4'(MAX_ATAQUES);
  localparam logic [3:0] HITS_ALVO   = 4'(HITS_VITORIA);

  logic conf;

  modulo_debounce_pulso #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
    .clk     (clk),
    .rst     (clr),
    .btn_n_i (bus.button_clk),
    .conf_o  (conf)
  );

  estado_t    estado_q, estado_d;
  logic       po_load_q, po_load_d;
  logic       at_write_q, at_write_d;
  logic       mat_clr_q, mat_clr_d;
  logic [1:0] status_q, status_d;
  logic [1:0] resultado_q, resultado_d;
  logic [3:0] ataques_q, ataques_d;
  logic [3:0] acertos_q, acertos_d;

  always_comb begin
    estado_d    = estado_q;
    po_load_d   = 1'b0;
    at_write_d  = 1'b0;
    mat_clr_d   = 1'b0;
    resultado_d = resultado_q;
    ataques_d   = ataques_q;
    acertos_d   = acertos_q;

    case (estado_q)
      POSICIONA: begin
        if (conf) begin
          po_load_d = 1'b1;
          estado_d  = ATAQUE;
        end
      end
      ATAQUE: begin
        if (conf) begin
          if (!alvo_valido(bus.hh2) || bus.cell_atacada) begin
            resultado_d = RES_REJEITADO;
          end else begin
            at_write_d = 1'b1;
            ataques_d  = dec_sat(ataques_q);
            if (bus.cell_navio) begin
              acertos_d   = inc_sat(acertos_q);
              resultado_d = RES_ACERTO;
            end else begin
              resultado_d = RES_AGUA;
            end
            estado_d = AVALIA;
          end
        end
      end
      // Counters already hold the post-attack values here; victory is tested first.
      AVALIA: begin
        if (acertos_q == HITS_ALVO)   estado_d = VITORIA;
        else if (ataques_q == 4'd0)   estado_d = DERROTA;
        else                          estado_d = ATAQUE;
      end
      VITORIA, DERROTA: begin
        if (conf) begin
          mat_clr_d   = 1'b1;
          ataques_d   = ATAQUES_INI;
          acertos_d   = 4'd0;
          resultado_d = RES_NENHUM;
          estado_d    = POSICIONA;
        end
      end
      default: estado_d = POSICIONA;
    endcase

    status_d = status_de(estado_d);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      estado_q    <= POSICIONA;
      po_load_q   <= 1'b0;
      at_write_q  <= 1'b0;
      mat_clr_q   <= 1'b0;
      status_q    <= ST_POSICIONANDO;
      resultado_q <= RES_NENHUM;
      ataques_q   <= ATAQUES_INI;
      acertos_q   <= 4'd0;
    end else begin
      estado_q    <= estado_d;
      po_load_q   <= po_load_d;
      at_write_q  <= at_write_d;
      mat_clr_q   <= mat_clr_d;
      status_q    <= status_d;
      resultado_q <= resultado_d;
      ataques_q   <= ataques_d;
      acertos_q   <= acertos_d;
    end
  end

  assign bus.po_load      = po_load_q;
  assign bus.at_write     = at_write_q;
  assign bus.mat_clr      = mat_clr_q;
  assign bus.status       = status_q;
  assign bus.resultado    = resultado_q;
  assign bus.ataques_rest = ataques_q;
  assign bus.acertos      = acertos_q;

endmodule

// File: tb/tb_modulo_controle_jogo.sv
// Scoreboard bench: each expected output snapshot is queued before stimulus; a monitor pops on every output change.
module tb_modulo_controle_jogo;

  typedef logic [14:0] snap_t;

  logic clk = 1'b0;
  logic clr = 1'b1;

  always #5 clk = ~clk;

  modulo_controle_jogo_if bus ();

  modulo_controle_jogo #(
    .DEB_CYCLES   (4),
    .MAX_ATAQUES  (12),
    .HITS_VITORIA (6)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  snap_t exp_q[$];
  snap_t last_exp;

  function automatic snap_t mk(input logic po, input logic aw, input logic mc,
                               input logic [1:0] st, input logic [1:0] res,
                               input logic [3:0] ata, input logic [3:0] ace);
    return {po, aw, mc, st, res, ata, ace};
  endfunction

  localparam snap_t RST_SNAP = {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'd12, 4'd0};

  function automatic snap_t cur_snap();
    return {bus.po_load, bus.at_write, bus.mat_clr, bus.status, bus.resultado,
            bus.ataques_rest, bus.acertos};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h (fields po,aw,mc,status,res,ataques,acertos)", name, act, req);
    end
  endtask

  task automatic expect_snap(input snap_t s);
    if (s != last_exp) begin
      exp_q.push_back(s);
      last_exp = s;
    end
  endtask

  // Monitor: any change of the output bundle outside reset must match the queue head.
  initial begin
    snap_t prev, s, e;
    prev = RST_SNAP;
    forever begin
      @(negedge clk);
      s = cur_snap();
      if (clr) begin
        prev = s;
      end else if (s != prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output got=%h required=no_change", s);
        end else begin
          e = exp_q.pop_front();
          check("output_event", 32'(s), 32'(e));
        end
        prev = s;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic btn(input logic v, input int n);
    repeat (n) begin
      @(posedge clk);
      #1 bus.button_clk = v;
    end
  endtask

  task automatic press();
    btn(1'b0, 8);
    btn(1'b1, 10);
  endtask

  task automatic set_target(input logic [5:0] hh, input logic navio, input logic atacada);
    @(posedge clk);
    #1;
    bus.hh2          = hh;
    bus.cell_navio   = navio;
    bus.cell_atacada = atacada;
  endtask

  task automatic place();
    expect_snap(mk(1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 4'd12, 4'd0));
    expect_snap(mk(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 4'd12, 4'd0));
    press();
  endtask

  task automatic new_game();
    expect_snap(mk(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 4'd12, 4'd0));
    expect_snap(RST_SNAP);
    press();
  endtask

  task automatic do_attack(input logic [5:0] hh, input logic navio, input logic [3:0] ata,
                           input logic [3:0] ace, input logic [1:0] st_after);
    logic [1:0] res;
    res = navio ? 2'b10 : 2'b01;
    expect_snap(mk(1'b0, 1'b1, 1'b0, 2'b01, res, ata, ace));
    expect_snap(mk(1'b0, 1'b0, 1'b0, st_after, res, ata, ace));
    set_target(hh, navio, 1'b0);
    press();
  endtask

  task automatic do_reject(input logic [5:0] hh, input logic atacada,
                           input logic [3:0] ata, input logic [3:0] ace);
    expect_snap(mk(1'b0, 1'b0, 1'b0, 2'b01, 2'b11, ata, ace));
    set_target(hh, 1'b0, atacada);
    press();
  endtask

  initial begin
    bit seen;
    bus.button_clk   = 1'b1;
    bus.hh2          = 6'd0;
    bus.cell_navio   = 1'b0;
    bus.cell_atacada = 1'b0;
    last_exp         = RST_SNAP;
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check("reset_state", 32'(cur_snap()), 32'(RST_SNAP));

    // Short press and bounce must not reach the FSM; the long press places.
    btn(1'b0, 3);
    btn(1'b1, 10);
    btn(1'b0, 1); btn(1'b1, 1); btn(1'b0, 1); btn(1'b1, 1);
    place();

    do_attack(6'b011_010, 1'b1, 4'd11, 4'd1, 2'b01);
    do_reject(6'b011_010, 1'b1, 4'd11, 4'd1);
    do_attack(6'b000_000, 1'b0, 4'd10, 4'd1, 2'b01);
    do_reject(6'b111_000, 1'b0, 4'd10, 4'd1);
    do_attack(6'b000_001, 1'b0, 4'd9, 4'd1, 2'b01);
    do_reject(6'b000_101, 1'b0, 4'd9, 4'd1);

    for (int i = 2; i <= 6; i++)
      do_attack({3'd5, 3'(i - 2)}, 1'b1, 4'(10 - i), 4'(i), (i == 6) ? 2'b10 : 2'b01);
    new_game();

    place();
    for (int k = 1; k <= 12; k++)
      do_attack({3'(k % 7), 3'(k % 5)}, 1'b0, 4'(12 - k), 4'd0, (k == 12) ? 2'b11 : 2'b01);
    new_game();

    // Last attack is also the winning hit: victory beats defeat.
    place();
    for (int k = 1; k <= 6; k++)
      do_attack({3'(k % 7), 3'd0}, 1'b0, 4'(12 - k), 4'd0, 2'b01);
    for (int j = 1; j <= 5; j++)
      do_attack({3'(j), 3'd3}, 1'b1, 4'(6 - j), 4'(j), 2'b01);
    do_attack(6'b110_100, 1'b1, 4'd0, 4'd6, 2'b10);
    new_game();

    // Asynchronous reset while the FSM sits in AVALIA.
    place();
    expect_snap(mk(1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 4'd11, 4'd1));
    set_target(6'b010_010, 1'b1, 1'b0);
    bus.button_clk = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus.at_write === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL avalia_wait got=no_at_write required=at_write within 40 cycles");
    end
    #1 clr = 1'b1;
    #1 check("clr_in_avalia", 32'(cur_snap()), 32'(RST_SNAP));
    bus.button_clk = 1'b1;
    last_exp = RST_SNAP;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    repeat (4) @(posedge clk);

    place();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
